// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// The fetch stage drives the fetch address. The memory returns a 10-byte
// window starting at that address, plus an invalid-address flag.
interface fetch_stage_if;
    logic [63:0] imem_addr;
    logic [79:0] imem_bytes;
    logic        imem_error;

    modport master (
        output imem_addr,
        input  imem_bytes,
        input  imem_error
    );

    modport slave (
        input  imem_addr,
        output imem_bytes,
        output imem_error
    );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage.
// - Holds the predicted-PC register F and selects the fetch PC. That selection
//   also covers mispredicted-branch and ret recovery.
// - Decodes the instruction window from instruction memory.
// - Computes valP and the next predicted PC.
// - Loads the D pipeline register that feeds decode.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 F_stall,
    input  logic                 D_stall,
    input  logic                 D_bubble,
    input  logic [3:0]           M_icode,
    input  logic                 M_Cnd,
    input  logic [63:0]          M_valA,
    input  logic [3:0]           W_icode,
    input  logic [63:0]          W_valM,
    fetch_stage_if.master        imem,
    output logic [2:0]           D_stat,
    output logic [3:0]           D_icode,
    output logic [3:0]           D_ifun,
    output logic [3:0]           D_rA,
    output logic [3:0]           D_rB,
    output logic [63:0]          D_valC,
    output logic [63:0]          D_valP
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_HLT    = 3'd2;
    localparam logic [2:0] S_ADR    = 3'd3;
    localparam logic [2:0] S_INS    = 3'd4;

    // Predicted-PC register
    logic [63:0] F_predPC_q, F_predPC_d;

    // D pipeline register
    logic [2:0]  D_stat_q,  D_stat_d;
    logic [3:0]  D_icode_q, D_icode_d;
    logic [3:0]  D_ifun_q,  D_ifun_d;
    logic [3:0]  D_rA_q,    D_rA_d;
    logic [3:0]  D_rB_q,    D_rB_d;
    logic [63:0] D_valC_q,  D_valC_d;
    logic [63:0] D_valP_q,  D_valP_d;

    // Fetch-side combinational values
    logic [63:0] f_pc_s;
    logic [7:0]  byte0_s;
    logic [7:0]  byte1_s;
    logic [3:0]  f_icode_s;
    logic [3:0]  f_ifun_s;
    logic        instr_valid_s;
    logic        need_regids_s;
    logic        need_valC_s;
    logic [3:0]  f_rA_s;
    logic [3:0]  f_rB_s;
    logic [63:0] f_valC_s;
    logic [63:0] f_valP_s;
    logic [63:0] f_predPC_s;
    logic [2:0]  f_stat_s;

    // Fetch PC selection: a not-taken branch in M beats a ret in W, which beats the prediction
    always_comb begin
        f_pc_s = F_predPC_q;
        if ((M_icode == I_JXX) && !M_Cnd) begin
            f_pc_s = M_valA;
        end else if (W_icode == I_RET) begin
            f_pc_s = W_valM;
        end else begin
            f_pc_s = F_predPC_q;
        end
    end

    assign imem.imem_addr = f_pc_s;
    assign byte0_s        = imem.imem_bytes[7:0];
    assign byte1_s        = imem.imem_bytes[15:8];

    // Split icode/ifun. A bad fetch address turns the instruction into a nop.
    always_comb begin
        f_icode_s = byte0_s[7:4];
        f_ifun_s  = byte0_s[3:0];
        if (imem.imem_error) begin
            f_icode_s = I_NOP;
            f_ifun_s  = 4'h0;
        end else begin
            f_icode_s = byte0_s[7:4];
            f_ifun_s  = byte0_s[3:0];
        end
    end

    // Legal icode/ifun combinations
    always_comb begin
        instr_valid_s = 1'b0;
        case (f_icode_s)
            I_OPQ:              instr_valid_s = (f_ifun_s <= 4'd3);
            I_JXX, I_RRMOVQ:    instr_valid_s = (f_ifun_s <= 4'd6);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ:
                                instr_valid_s = (f_ifun_s == 4'd0);
            default:            instr_valid_s = 1'b0;
        endcase
    end

    // Which instruction formats carry a register byte and/or a constant word
    always_comb begin
        need_regids_s = 1'b0;
        need_valC_s   = 1'b0;
        case (f_icode_s)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                need_regids_s = 1'b1;
                need_valC_s   = 1'b0;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids_s = 1'b1;
                need_valC_s   = 1'b1;
            end
            I_JXX, I_CALL: begin
                need_regids_s = 1'b0;
                need_valC_s   = 1'b1;
            end
            default: begin
                need_regids_s = 1'b0;
                need_valC_s   = 1'b0;
            end
        endcase
    end

    // Register specifiers and constant word. The constant word follows the register byte when there is one.
    always_comb begin
        f_rA_s   = R_NONE;
        f_rB_s   = R_NONE;
        f_valC_s = 64'h0;
        if (need_regids_s) begin
            f_rA_s = byte1_s[7:4];
            f_rB_s = byte1_s[3:0];
        end else begin
            f_rA_s = R_NONE;
            f_rB_s = R_NONE;
        end
        if (need_valC_s && need_regids_s) begin
            f_valC_s = imem.imem_bytes[79:16];
        end else if (need_valC_s) begin
            f_valC_s = imem.imem_bytes[71:8];
        end else begin
            f_valC_s = 64'h0;
        end
    end

    // Fall-through PC (wraps silently). Jumps and calls predict their target.
    always_comb begin
        f_valP_s = f_pc_s + 64'd1 + {63'd0, need_regids_s}
                 + (need_valC_s ? 64'd8 : 64'd0);
        if ((f_icode_s == I_JXX) || (f_icode_s == I_CALL)) begin
            f_predPC_s = f_valC_s;
        end else begin
            f_predPC_s = f_valP_s;
        end
    end

    // Fetch status: an address error wins over an illegal instruction, which wins over halt
    always_comb begin
        f_stat_s = S_AOK;
        if (imem.imem_error) begin
            f_stat_s = S_ADR;
        end else if (!instr_valid_s) begin
            f_stat_s = S_INS;
        end else if (f_icode_s == I_HALT) begin
            f_stat_s = S_HLT;
        end else begin
            f_stat_s = S_AOK;
        end
    end

    // Next value of the predicted PC: reset overrides stall
    always_comb begin
        F_predPC_d = F_predPC_q;
        if (reset) begin
            F_predPC_d = RESET_PC;
        end else if (!F_stall) begin
            F_predPC_d = f_predPC_s;
        end else begin
            F_predPC_d = F_predPC_q;
        end
    end

    // Next value of D: reset and bubble insert a nop and win over stall
    always_comb begin
        D_stat_d  = D_stat_q;
        D_icode_d = D_icode_q;
        D_ifun_d  = D_ifun_q;
        D_rA_d    = D_rA_q;
        D_rB_d    = D_rB_q;
        D_valC_d  = D_valC_q;
        D_valP_d  = D_valP_q;
        if (reset || D_bubble) begin
            D_stat_d  = S_AOK;
            D_icode_d = I_NOP;
            D_ifun_d  = 4'h0;
            D_rA_d    = R_NONE;
            D_rB_d    = R_NONE;
            D_valC_d  = 64'h0;
            D_valP_d  = 64'h0;
        end else if (!D_stall) begin
            D_stat_d  = f_stat_s;
            D_icode_d = f_icode_s;
            D_ifun_d  = f_ifun_s;
            D_rA_d    = f_rA_s;
            D_rB_d    = f_rB_s;
            D_valC_d  = f_valC_s;
            D_valP_d  = f_valP_s;
        end else begin
            D_stat_d  = D_stat_q;
            D_icode_d = D_icode_q;
            D_ifun_d  = D_ifun_q;
            D_rA_d    = D_rA_q;
            D_rB_d    = D_rB_q;
            D_valC_d  = D_valC_q;
            D_valP_d  = D_valP_q;
        end
    end

    // State update for F and D
    always_ff @(posedge clock) begin
        F_predPC_q <= F_predPC_d;
        D_stat_q   <= D_stat_d;
        D_icode_q  <= D_icode_d;
        D_ifun_q   <= D_ifun_d;
        D_rA_q     <= D_rA_d;
        D_rB_q     <= D_rB_d;
        D_valC_q   <= D_valC_d;
        D_valP_q   <= D_valP_d;
    end

    assign D_stat  = D_stat_q;
    assign D_icode = D_icode_q;
    assign D_ifun  = D_ifun_q;
    assign D_rA    = D_rA_q;
    assign D_rB    = D_rB_q;
    assign D_valC  = D_valC_q;
    assign D_valP  = D_valP_q;

endmodule
